// File: rtl/i3c_axi_sub_rr_arb_if.sv
// Bus bundle between NCH requester channels, the arbiter and the shared component.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface i3c_axi_sub_rr_arb_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned UW  = 32,
  parameter int unsigned IW  = 1
);
  localparam int unsigned BC   = DW / 8;
  localparam int unsigned IdxW = $clog2(NCH);

  // Requester side, packed per channel
  logic [NCH-1:0]    s_dv;
  logic [NCH-1:0]    s_write;
  logic [NCH-1:0]    s_last;
  logic [NCH*AW-1:0] s_addr;
  logic [NCH*UW-1:0] s_user;
  logic [NCH*IW-1:0] s_id;
  logic [NCH*DW-1:0] s_wdata;
  logic [NCH*BC-1:0] s_wstrb;
  logic [NCH*3-1:0]  s_size;
  logic [NCH-1:0]    s_hld;
  logic [NCH-1:0]    s_err;
  logic [NCH-1:0]    s_rvld;
  logic [DW-1:0]     s_rdata;

  // Component side
  logic              dv;
  logic [AW-1:0]     addr;
  logic              write;
  logic [UW-1:0]     user;
  logic [IW-1:0]     id;
  logic [DW-1:0]     wdata;
  logic [BC-1:0]     wstrb;
  logic [2:0]        size;
  logic              last;
  logic              hld;
  logic              rd_err;
  logic              wr_err;
  logic [DW-1:0]     rdata;

  logic [IdxW-1:0]   gnt_idx;

  modport slave (
    input  s_dv, s_write, s_last, s_addr, s_user, s_id, s_wdata, s_wstrb, s_size,
    input  hld, rd_err, wr_err, rdata,
    output s_hld, s_err, s_rvld, s_rdata,
    output dv, addr, write, user, id, wdata, wstrb, size, last, gnt_idx
  );

  modport master (
    output s_dv, s_write, s_last, s_addr, s_user, s_id, s_wdata, s_wstrb, s_size,
    output hld, rd_err, wr_err, rdata,
    input  s_hld, s_err, s_rvld, s_rdata,
    input  dv, addr, write, user, id, wdata, wstrb, size, last, gnt_idx
  );
endinterface

// File: rtl/i3c_axi_sub_rr_arb.sv
// Multi-channel beat arbiter for a shared I3C/AXI sub-component: round-robin or fixed
// priority, burst locking, and read/error return routing through a latency-matched pipe.
module i3c_axi_sub_rr_arb #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned UW       = 32,
  parameter int unsigned IW       = 1,
  parameter int unsigned C_LAT    = 0,
  parameter int unsigned PRI_MODE = 0
) (
  input logic                clk,
  input logic                rst_n,
  i3c_axi_sub_rr_arb_if.slave bus
);
  localparam int unsigned BC    = DW / 8;
  localparam int unsigned IdxW  = $clog2(NCH);
  localparam int unsigned PipeD = (C_LAT > 0) ? C_LAT : 1;

  typedef enum logic [0:0] {StIdle, StLock} lock_st_e;

  lock_st_e        st_q, st_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gnt_q, gnt;
  logic            any_req;
  logic            accept;
  logic            acc_rd;
  logic            acc_wr;
  logic            ret_vld;
  logic [IdxW-1:0] ret_idx;
  logic [NCH-1:0]  hld_vec;
  logic [NCH-1:0]  rvld_vec;
  logic [NCH-1:0]  err_vec;
  logic [NCH-1:0]  acc_vec;

  assign any_req = |bus.s_dv;

  // Grant: locked channel, else search; an idle cycle keeps the previous grant.
  always_comb begin
    gnt = gnt_q;
    if (!rst_n) begin
      gnt = '0;
    end else if (st_q == StLock) begin
      gnt = gnt_q;
    end else if (any_req) begin
      if (PRI_MODE == 1) begin
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
          if (bus.s_dv[i]) gnt = IdxW'(i);
        end
      end else begin
        // Walk downward so the last hit is the first channel after ptr.
        for (int i = int'(NCH); i >= 1; i--) begin
          if (bus.s_dv[(int'(ptr_q) + i) % int'(NCH)]) begin
            gnt = IdxW'((int'(ptr_q) + i) % int'(NCH));
          end
        end
      end
    end
  end

  // Component-facing beat
  assign bus.dv      = any_req;
  assign bus.write   = bus.s_write[gnt];
  assign bus.last    = bus.s_last[gnt];
  assign bus.addr    = bus.s_addr[int'(gnt) * AW +: AW];
  assign bus.user    = bus.s_user[int'(gnt) * UW +: UW];
  assign bus.id      = bus.s_id[int'(gnt) * IW +: IW];
  assign bus.wdata   = bus.s_wdata[int'(gnt) * DW +: DW];
  assign bus.wstrb   = bus.s_wstrb[int'(gnt) * BC +: BC];
  assign bus.size    = bus.s_size[int'(gnt) * 3 +: 3];
  assign bus.gnt_idx = gnt;
  assign bus.s_rdata = bus.rdata;

  assign accept = bus.dv && !bus.hld;
  assign acc_rd = accept && !bus.write;
  assign acc_wr = accept && bus.write;

  for (genvar k = 0; k < NCH; k++) begin : gen_hld
    assign hld_vec[k] = bus.hld || (gnt != IdxW'(k)) || !bus.s_dv[k];
  end
  assign bus.s_hld = hld_vec;

  // Lock FSM and round-robin pointer; a stalled grant never locks.
  always_comb begin
    st_d  = st_q;
    ptr_d = ptr_q;
    if (accept) begin
      if (bus.last) begin
        st_d = StIdle;
        if (PRI_MODE == 0) ptr_d = gnt;
      end else begin
        st_d = StLock;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= StIdle;
      ptr_q <= IdxW'(NCH - 1);
      gnt_q <= '0;
    end else begin
      st_q  <= st_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt;
    end
  end

  // Read return pipe: advances every cycle so it tracks the component's fixed latency.
  if (C_LAT > 0) begin : gen_pipe
    logic [PipeD-1:0] pv_q;
    logic [IdxW-1:0]  pidx_q [PipeD];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pv_q <= '0;
        for (int i = 0; i < int'(PipeD); i++) pidx_q[i] <= '0;
      end else begin
        pv_q[0]   <= acc_rd;
        pidx_q[0] <= gnt;
        for (int i = 1; i < int'(PipeD); i++) begin
          pv_q[i]   <= pv_q[i-1];
          pidx_q[i] <= pidx_q[i-1];
        end
      end
    end

    assign ret_vld = pv_q[PipeD-1];
    assign ret_idx = pidx_q[PipeD-1];
  end else begin : gen_nopipe
    assign ret_vld = acc_rd;
    assign ret_idx = gnt;
  end

  // Read return and write error may land together; same channel gets the OR.
  always_comb begin
    rvld_vec = '0;
    err_vec  = '0;
    if (rst_n) begin
      if (ret_vld) begin
        rvld_vec[ret_idx] = 1'b1;
        err_vec[ret_idx]  = bus.rd_err;
      end
      if (acc_wr) err_vec[gnt] = err_vec[gnt] | bus.wr_err;
    end
  end

  assign bus.s_rvld = rvld_vec;
  assign bus.s_err  = err_vec;

  assign acc_vec = bus.s_dv & ~hld_vec;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(acc_vec));
    end
  end

endmodule

// File: tb/tb_i3c_axi_sub_rr_arb.sv
// Directed bench: vector table on a fixed-priority zero-latency instance, hand sequences
// on a round-robin two-cycle-latency instance.
module tb_i3c_axi_sub_rr_arb;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i3c_axi_sub_rr_arb_if #(.NCH(N)) ia ();
  i3c_axi_sub_rr_arb_if #(.NCH(N)) ib ();

  i3c_axi_sub_rr_arb #(.NCH(N), .C_LAT(2), .PRI_MODE(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  i3c_axi_sub_rr_arb #(.NCH(N), .C_LAT(0), .PRI_MODE(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] dv;
    logic [3:0] wr;
    logic       hld;
    logic       rde;
    logic       wre;
    logic [1:0] gnt;
    logic [3:0] rvld;
    logic [3:0] err;
    logic [3:0] shld;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv_a(input logic [3:0] dv, input logic [3:0] wr, input logic [3:0] last,
                       input logic hld, input logic rde, input logic wre);
    ia.s_dv    = dv;
    ia.s_write = wr;
    ia.s_last  = last;
    ia.hld     = hld;
    ia.rd_err  = rde;
    ia.wr_err  = wre;
  endtask

  task automatic drv_b(input logic [3:0] dv, input logic [3:0] wr, input logic [3:0] last,
                       input logic hld, input logic rde, input logic wre);
    ib.s_dv    = dv;
    ib.s_write = wr;
    ib.s_last  = last;
    ib.hld     = hld;
    ib.rd_err  = rde;
    ib.wr_err  = wre;
  endtask

  initial begin
    //            dv       wr       hld   rde   wre   gnt   rvld     err      shld
    tbl[0] = '{4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000, 4'b1110};
    tbl[1] = '{4'b1001, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0000, 4'b0001, 4'b1110};
    tbl[2] = '{4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 4'b1000, 4'b1000, 4'b0111};
    tbl[3] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 4'b1111};
    tbl[4] = '{4'b0110, 4'b0110, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000, 4'b1111};
    tbl[5] = '{4'b0110, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0010, 4'b0000, 4'b1101};
    tbl[6] = '{4'b1100, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0100, 4'b1011};
    tbl[7] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0001, 4'b1110};

    ia.s_addr = '0; ia.s_user = '0; ia.s_id = '0; ia.s_wdata = '0;
    ia.s_wstrb = '0; ia.s_size = '0; ia.rdata = 32'h1234_5678;
    ib.s_addr = '0; ib.s_user = '0; ib.s_id = '0; ib.s_wdata = '0;
    ib.s_wstrb = '0; ib.s_size = '0; ib.rdata = 32'hCAFE_0001;
    for (int k = 0; k < int'(N); k++) begin
      ia.s_addr[k*32 +: 32] = 32'hA000_0000 | k;
      ib.s_addr[k*32 +: 32] = 32'hA000_0000 | k;
    end

    // Reset: grant forced to 0, no returns even with a live read request
    rst_n = 1'b0;
    drv_a(4'b0010, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
    drv_b(4'b0010, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #1;
    check("rst_a_gnt", 32'(ia.gnt_idx), 32'd0);
    check("rst_a_rvld", 32'(ia.s_rvld), 32'd0);
    check("rst_a_err", 32'(ia.s_err), 32'd0);
    check("rst_b_rvld", 32'(ib.s_rvld), 32'd0);
    check("rst_b_err", 32'(ib.s_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drv_a(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    drv_b(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("b_rdata", 32'(ib.s_rdata), 32'hCAFE_0001);

    // Fixed priority, zero latency: vector table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drv_b(tbl[i].dv, tbl[i].wr, 4'b1111, tbl[i].hld, tbl[i].rde, tbl[i].wre);
      #1;
      check($sformatf("tbl%0d_gnt", i), 32'(ib.gnt_idx), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_rvld", i), 32'(ib.s_rvld), 32'(tbl[i].rvld));
      check($sformatf("tbl%0d_err", i), 32'(ib.s_err), 32'(tbl[i].err));
      check($sformatf("tbl%0d_shld", i), 32'(ib.s_hld), 32'(tbl[i].shld));
      check($sformatf("tbl%0d_addr", i), ib.addr, 32'hA000_0000 | 32'(tbl[i].gnt));
    end

    // Fixed priority starvation: channel 3 waits while channel 0 keeps requesting
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drv_b(4'b1001, 4'b1001, 4'b1111, 1'b0, 1'b0, 1'b0);
      #1;
      check($sformatf("pri_gnt%0d", i), 32'(ib.gnt_idx), 32'd0);
      check($sformatf("pri_hld3_%0d", i), 32'(ib.s_hld[3]), 32'd1);
    end
    @(negedge clk);
    drv_b(4'b1000, 4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0);
    #1;
    check("pri_gnt3", 32'(ib.gnt_idx), 32'd3);
    @(negedge clk);
    drv_b(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Round robin over four single-beat requesters
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drv_a(4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
      #1;
      check($sformatf("rr_gnt%0d", i), 32'(ia.gnt_idx), 32'(i % 4));
    end
    @(negedge clk);
    drv_a(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Four-beat write burst on channel 1, channel 2 joins at beat 2
    @(negedge clk);
    drv_a(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
    #1;
    check("burst_gnt0", 32'(ia.gnt_idx), 32'd1);
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      drv_a(4'b0110, 4'b0110, (b == 3) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 1'b0);
      #1;
      check($sformatf("burst_gnt%0d", b), 32'(ia.gnt_idx), 32'd1);
      check($sformatf("burst_hld2_%0d", b), 32'(ia.s_hld[2]), 32'd1);
    end
    @(negedge clk);
    drv_a(4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
    #1;
    check("burst_after", 32'(ia.gnt_idx), 32'd2);
    @(negedge clk);
    drv_a(4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
    #1;
    check("ptr_to3", 32'(ia.gnt_idx), 32'd3);

    // Component stall on channel 0 with channel 3 also waiting
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv_a(4'b1001, 4'b1001, 4'b1001, 1'b1, 1'b0, 1'b0);
      #1;
      check($sformatf("stall_gnt%0d", i), 32'(ia.gnt_idx), 32'd0);
      check($sformatf("stall_shld%0d", i), 32'(ia.s_hld), 32'hF);
    end
    @(negedge clk);
    drv_a(4'b1001, 4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0);
    #1;
    check("stall_rel0", 32'(ia.gnt_idx), 32'd0);
    check("stall_rel_shld", 32'(ia.s_hld), 32'hE);
    @(negedge clk);
    #1;
    check("stall_rel3", 32'(ia.gnt_idx), 32'd3);
    @(negedge clk);
    drv_a(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Two-cycle read return: channel 2 then channel 0, overlapping write errors
    @(negedge clk);
    drv_a(4'b0100, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
    #1;
    check("rd_gnt2", 32'(ia.gnt_idx), 32'd2);
    check("rd_t0_rvld", 32'(ia.s_rvld), 32'd0);
    @(negedge clk);
    drv_a(4'b0001, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
    #1;
    check("rd_gnt0", 32'(ia.gnt_idx), 32'd0);
    check("rd_t1_rvld", 32'(ia.s_rvld), 32'd0);
    check("rd_t1_err", 32'(ia.s_err), 32'd0);
    @(negedge clk);
    drv_a(4'b0010, 4'b0010, 4'b1111, 1'b0, 1'b1, 1'b1);
    #1;
    check("rd_t2_gnt", 32'(ia.gnt_idx), 32'd1);
    check("rd_t2_rvld", 32'(ia.s_rvld), 32'b0100);
    check("rd_t2_err", 32'(ia.s_err), 32'b0110);
    @(negedge clk);
    drv_a(4'b0001, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b1);
    #1;
    check("rd_t3_rvld", 32'(ia.s_rvld), 32'b0001);
    check("rd_t3_err", 32'(ia.s_err), 32'b0001);
    @(negedge clk);
    drv_a(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    #1;
    check("rd_t4_rvld", 32'(ia.s_rvld), 32'd0);
    check("rd_t4_err", 32'(ia.s_err), 32'd0);

    // Reset in the middle of a channel 2 read burst
    @(negedge clk);
    drv_a(4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    #1;
    check("mr_gnt2", 32'(ia.gnt_idx), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    drv_a(4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    #1;
    check("mr_in_rst_gnt", 32'(ia.gnt_idx), 32'd0);
    check("mr_in_rst_rvld", 32'(ia.s_rvld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drv_a(4'b0110, 4'b0110, 4'b0110, 1'b0, 1'b1, 1'b0);
    #1;
    check("mr_post_gnt", 32'(ia.gnt_idx), 32'd1);
    check("mr_post_rvld0", 32'(ia.s_rvld), 32'd0);
    check("mr_post_err0", 32'(ia.s_err), 32'd0);
    @(negedge clk);
    #1;
    check("mr_post_gnt2", 32'(ia.gnt_idx), 32'd2);
    check("mr_post_rvld1", 32'(ia.s_rvld), 32'd0);
    @(negedge clk);
    drv_a(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i3c_axi_sub_rr_arb.md
I3C_AXI_SUB_RR_ARB -- requirements
Module: i3c_axi_sub_rr_arb

Interface
REQ-001 SHALL have parameter NCH, default 2: number of requester channels, 2..8.
REQ-002 SHALL have parameter AW, default 32: byte address width.
REQ-003 SHALL have parameter DW, default 32: data width. BC=DW/8 is derived.
REQ-004 SHALL have parameter UW, default 32: user width.
REQ-005 SHALL have parameter IW, default 1: ID width.
REQ-006 SHALL have parameter C_LAT, default 0: component read latency in cycles from accepted beat to rdata, 0..4.
REQ-007 SHALL have parameter PRI_MODE, default 0: 0 = round-robin, 1 = fixed priority with lowest index highest.
REQ-008 SHALL have port clk, input, 1: the single clock.
REQ-009 SHALL have port rst_n, input, 1: synchronous active-low reset, sampled on the rising edge of clk.
REQ-010 SHALL have port s_dv, input, NCH: per-channel beat valid.
REQ-011 SHALL have port s_write, input, NCH: per-channel direction, 1 = write.
REQ-012 SHALL have port s_last, input, NCH: final beat of a burst.
REQ-013 SHALL have ports s_addr (NCH*AW), s_user (NCH*UW), s_id (NCH*IW), s_wdata (NCH*DW), s_wstrb (NCH*BC) and s_size (NCH*3), all inputs, packed per channel with channel k at slice k.
REQ-014 SHALL have port s_hld, output, NCH: per-channel hold.
REQ-015 SHALL have port s_err, output, NCH: per-channel error return.
REQ-016 SHALL have port s_rvld, output, NCH: per-channel read-data valid.
REQ-017 SHALL have port s_rdata, output, DW: read data broadcast to all channels.
REQ-018 SHALL have ports dv, addr, write, user, id, wdata, wstrb, size and last, outputs: the beat of the granted channel, presented to the component.
REQ-019 SHALL have ports hld, rd_err, wr_err (1 bit each) and rdata (DW), inputs from the component.
REQ-020 SHALL have port gnt_idx, output, $clog2(NCH): index of the current grant.

Function
REQ-021 SHALL drive dv = OR of s_dv; all payload outputs SHALL be muxed from gnt_idx.
REQ-022 SHALL select the grant combinationally each cycle.
REQ-023 Grant selection while locked: the locked channel.
REQ-024 Grant selection in mode 0, unlocked: the first requesting channel searched upward from ptr+1, wrapping modulo NCH.
REQ-025 Grant selection in mode 1, unlocked: the lowest-index requesting channel.
REQ-026 Grant selection with no request: gnt_idx SHALL hold its previous value.
REQ-027 Lock state machine: IDLE -> LOCK when the granted beat is accepted (dv && !hld) with last=0. LOCK -> IDLE on an accepted beat with last=1. An accepted beat with last=1 in IDLE stays in IDLE.
REQ-028 In LOCK, the grant SHALL stay on the locked channel even when that channel drops s_dv; other channels SHALL see hld.
REQ-029 A grant made while hld=1 SHALL NOT lock; it may re-arbitrate next cycle (unlocked).
REQ-030 ptr (mode 0) SHALL update to gnt_idx only on an accepted beat with last=1.
REQ-031 SHALL drive s_hld[k] = hld || (k != gnt_idx) || !s_dv[k] (the last term is don't-care).
REQ-032 wr_err SHALL route combinationally to s_err[gnt_idx] on an accepted write beat.
REQ-033 Read return: each accepted read beat SHALL push gnt_idx into a C_LAT-deep shift pipe.
REQ-034 With C_LAT=0, read return SHALL be combinational: s_rvld[gnt_idx] on the accepted read, with rd_err routed to s_err.
REQ-035 With C_LAT>0, after C_LAT cycles s_rvld[idx]=1 and s_err[idx]=rd_err. The pipe SHALL advance every cycle regardless of hld.
REQ-036 A read return and a write error on the same cycle for different channels SHALL both be delivered. If they target the same channel, s_err SHALL be their OR.
REQ-037 s_rdata SHALL equal rdata.
REQ-038 SHALL never accept beats from two channels in one cycle; assertion required.

Reset
REQ-039 While rst_n=0: lock=IDLE, ptr=NCH-1, gnt_idx=0, pipe cleared, s_rvld=0, s_err=0.
REQ-040 Reset mid-burst SHALL drop the lock and discard in-flight read returns; first cycle after reset arbitrates from channel 0.

Verification
REQ-041 NCH=4, mode 0, channels 0..3 each issuing continuous single-beat bursts -> grants 0,1,2,3,0 on consecutive cycles.
REQ-042 Channel 1 issues a 4-beat write burst; channel 2 requests at beat 2 -> gnt_idx=1 for 4 accepted beats, then 2; s_hld[2]=1 throughout the burst.
REQ-043 hld=1 for 3 cycles at the first beat of channel 0 while channel 3 also requests -> no lock, no ptr change; after release, channel 0 is accepted, then channel 3.
REQ-044 C_LAT=2, reads accepted from channels 2 then 0 on back-to-back cycles -> s_rvld[2] two cycles later, s_rvld[0] on the next cycle, with rd_err routed to match.
REQ-045 Mode 1, channels 0 and 3 requesting continuously -> channel 3 is never granted until channel 0 deasserts.
REQ-046 Reset asserted mid-burst on channel 2 with C_LAT=2 and a read in flight -> no s_rvld after reset; next grant goes to the lowest requesting channel.
